// File: rtl/reaction_timer_fsm.sv
// Reaction timer: pseudo-random wait from q_delay, then measures user reaction time in ms.
// Optional best-time tracking is built when the BEST_TIME_EN macro is defined.
`timescale 1ns/1ps

module reaction_timer_fsm #(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        react,
    input  logic [13:0] q_delay,
    output logic        stim_led,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        early,
    output logic        timeout,
    output logic [13:0] best_ms
);

    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [13:0]   MIN_DELAY = 14'(MIN_DELAY_MS);
    localparam logic [13:0]   TIMEOUT   = 14'(TIMEOUT_MS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REACT
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [13:0]   wait_q;
    logic [13:0]   cnt_q;
    logic [13:0]   result_q;
    logic          stim_q;
    logic          busy_q;
    logic          valid_q;
    logic          early_q;
    logic          timeout_q;
    logic          tick;

    // Only the low 12 bits of the delay counter form the random part of the wait.
    logic unused_q_delay_hi;
    assign unused_q_delay_hi = ^q_delay[13:12];

    assign tick = (presc_q == PRESC_MAX);

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            wait_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            stim_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            presc_q <= tick ? '0 : presc_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    presc_q <= '0;
                    if (start) begin
                        wait_q    <= MIN_DELAY + {2'b00, q_delay[11:0]};
                        early_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A reaction beats a wait expiry landing in the same cycle.
                    if (react) begin
                        early_q <= 1'b1;
                        busy_q  <= 1'b0;
                        presc_q <= '0;
                        state_q <= S_IDLE;
                    end else if (tick) begin
                        if (wait_q <= 14'd1) begin
                            stim_q  <= 1'b1;
                            cnt_q   <= '0;
                            presc_q <= '0;
                            state_q <= S_REACT;
                        end else begin
                            wait_q <= wait_q - 14'd1;
                        end
                    end
                end
                S_REACT: begin
                    if (react) begin
                        result_q <= cnt_q;
                        valid_q  <= 1'b1;
                        stim_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        presc_q  <= '0;
                        state_q  <= S_IDLE;
                    end else if (tick) begin
                        if (cnt_q >= TIMEOUT - 14'd1) begin
                            cnt_q     <= TIMEOUT;
                            result_q  <= TIMEOUT;
                            timeout_q <= 1'b1;
                            stim_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            presc_q   <= '0;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 14'd1;
                        end
                    end
                end
                default: begin
                    stim_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    presc_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stim_led     = stim_q;
    assign busy         = busy_q;
    assign result_ms    = result_q;
    assign result_valid = valid_q;
    assign early        = early_q;
    assign timeout      = timeout_q;

`ifdef BEST_TIME_EN
    logic [13:0] best_q;

    // Tracks the same event that raises result_valid, so early/timeout never touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_q <= 14'h3FFF;
        end else if (state_q == S_REACT && react && cnt_q < best_q) begin
            best_q <= cnt_q;
        end
    end

    assign best_ms = best_q;
`else
    assign best_ms = 14'h3FFF;
`endif

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Scoreboard bench for reaction_timer_fsm: stimulus pushes expected trial outcomes,
// a negedge monitor compares them whenever a trial ends (busy falls).
`timescale 1ns/1ps

module tb_reaction_timer_fsm;

    localparam int TICK = 10;
    localparam int MIN_D = 5;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic [13:0] q_delay = '0;
    logic        stim_led;
    logic        busy;
    logic [13:0] result_ms;
    logic        result_valid;
    logic        early;
    logic        timeout;
    logic [13:0] best_ms;

    reaction_timer_fsm #(
        .TICK_DIV    (TICK),
        .MIN_DELAY_MS(MIN_D),
        .TIMEOUT_MS  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .react       (react),
        .q_delay     (q_delay),
        .stim_led    (stim_led),
        .busy        (busy),
        .result_ms   (result_ms),
        .result_valid(result_valid),
        .early       (early),
        .timeout     (timeout),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rv;
        logic [13:0] res;
        logic        early_e;
        logic        tmo_e;
        logic        stim_e;
        logic [13:0] best;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          start_cyc = 0;
    logic [13:0] last_res = '0;
    logic [13:0] best_mdl = 14'h3FFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model of the held result and best time, then queue the trial-end expectation.
    task automatic expect_end(input logic rv, input logic [13:0] res, input logic early_e,
                              input logic tmo_e, input logic stim_e);
        exp_t e;
        if (rv) begin
            last_res = res;
`ifdef BEST_TIME_EN
            if (res < best_mdl) best_mdl = res;
`endif
        end
        if (tmo_e) last_res = 14'(TMO);
        e.rv = rv; e.res = last_res; e.early_e = early_e;
        e.tmo_e = tmo_e; e.stim_e = stim_e; e.best = best_mdl;
        exp_q.push_back(e);
    endtask

    task automatic expect_reset();
        exp_t e;
        last_res = '0;
        best_mdl = 14'h3FFF;
        e.rv = 1'b0; e.res = '0; e.early_e = 1'b0;
        e.tmo_e = 1'b0; e.stim_e = 1'b1; e.best = 14'h3FFF;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input bit is_start);
        if (is_start) start = 1'b1;
        else          react = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        react = 1'b0;
    endtask

    task automatic do_start();
        pulse(1'b1);
        start_cyc = cyc;
    endtask

    task automatic react_at(input int k);
        repeat (k) @(posedge clk);
        #1;
        pulse(1'b0);
    endtask

    task automatic wait_stim(input int exp_delay);
        int n = 0;
        while (!stim_led && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!stim_led) check("stim_rise_seen", 0, 1);
        else           check("stim_delay", cyc - start_cyc, exp_delay);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("trial_ended", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stim"}, stim_led, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result"}, result_ms, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_early"}, early, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_best"}, best_ms, 14'h3FFF);
    endtask

    // Monitor: a falling busy marks the end of a trial; result_valid is legal only there.
    logic busy_prev = 1'b0;
    logic stim_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (stim_led) stim_seen = 1'b1;
        if (busy_prev && !busy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_trial_end: got end expected none");
            end else begin
                e = exp_q.pop_front();
                check("end_result_valid", result_valid, e.rv);
                check("end_result_ms", result_ms, e.res);
                check("end_early", early, e.early_e);
                check("end_timeout", timeout, e.tmo_e);
                check("end_stim_seen", stim_seen, e.stim_e);
                check("end_best_ms", best_ms, e.best);
            end
            stim_seen = 1'b0;
        end else if (result_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_result_valid: got 1 expected 0");
        end
        busy_prev = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        int stim_cyc;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // react in IDLE does nothing
        pulse(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_react_busy", busy, 0);
        check("idle_react_early", early, 0);

        // Normal trial: wait 5+3 ticks, react after 7 ms
        q_delay = 14'd3;
        do_start();
        check("start_busy_latency", busy, 1);
        check("start_stim_off", stim_led, 0);
        wait_stim(8 * TICK);
        expect_end(1'b1, 14'd7, 1'b0, 1'b0, 1'b1);
        react_at(74);
        check("react_valid_latency", result_valid, 1);
        wait_idle();

        // Timeout: full 20 ms window with no reaction
        q_delay = 14'd0;
        do_start();
        wait_stim(5 * TICK);
        stim_cyc = cyc;
        expect_end(1'b0, 14'd0, 1'b0, 1'b1, 1'b1);
        while (busy && cyc - stim_cyc < 1000) begin
            @(posedge clk); #1;
        end
        check("timeout_window", cyc - stim_cyc, TMO * TICK);
        wait_idle();

        // React on the very tick that would end WAIT
        q_delay = 14'd0;
        do_start();
        expect_end(1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
        react_at(49);
        wait_idle();

        // React on the timeout tick counts as a valid 19 ms result
        q_delay = 14'd0;
        do_start();
        check("start_clears_early", early, 0);
        check("start_clears_timeout", timeout, 0);
        wait_stim(5 * TICK);
        expect_end(1'b1, 14'd19, 1'b0, 1'b0, 1'b1);
        react_at(199);
        wait_idle();

        // Reset in the middle of REACT; start in REACT is ignored first
        q_delay = 14'd2;
        do_start();
        wait_stim(7 * TICK);
        pulse(1'b1);
        check("react_ignores_start_stim", stim_led, 1);
        check("react_ignores_start_busy", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        expect_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        // Early reaction during WAIT
        q_delay = 14'd3;
        do_start();
        expect_end(1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
        react_at(30);
        wait_idle();
        check("early_sticky", early, 1);

        // Best-time sequence 12, 7, 15
        q_delay = 14'd0;
        do_start();
        check("next_start_clears_early", early, 0);
        wait_stim(5 * TICK);
        expect_end(1'b1, 14'd12, 1'b0, 1'b0, 1'b1);
        react_at(124);
        wait_idle();

        q_delay = 14'd3;
        do_start();
        saved = start_cyc;
        repeat (4) @(posedge clk);
        #1;
        q_delay = 14'd100;
        pulse(1'b1);
        start_cyc = saved;
        wait_stim(8 * TICK);
        expect_end(1'b1, 14'd7, 1'b0, 1'b0, 1'b1);
        react_at(74);
        wait_idle();

        q_delay = 14'd1;
        do_start();
        wait_stim(6 * TICK);
        expect_end(1'b1, 14'd15, 1'b0, 1'b0, 1'b1);
        react_at(154);
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
